// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: RAM read port, decode valid/ready output and redirect input.
// master = fetch stage, slave = RAM/decode/branch side.
interface inst_fetch_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int INST_W = 32
);
    logic              RamReadEnable;
    logic [ADDR_W-1:0] RamReadAddr;
    logic [DATA_W-1:0] RamReadData;

    logic              if_valid_o;
    logic              if_ready_i;
    logic [ADDR_W-1:0] if_pc_o;
    logic [INST_W-1:0] if_inst_o;
    logic              if_misalign_o;

    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;

    modport master (
        output RamReadEnable, RamReadAddr,
        input  RamReadData,
        output if_valid_o, if_pc_o, if_inst_o, if_misalign_o,
        input  if_ready_i,
        input  redirect_i, redirect_pc_i
    );

    modport slave (
        input  RamReadEnable, RamReadAddr,
        output RamReadData,
        input  if_valid_o, if_pc_o, if_inst_o, if_misalign_o,
        output if_ready_i,
        output redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: one aligned 64-bit RAM read per fetch, 1-cycle issue-to-valid, stalls on !if_ready_i.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt counters.
module inst_fetch #(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  fe
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]   perf_fetch_cnt,
    output logic [63:0]   perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] opc_q, opc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              mis_q, mis_d;
    logic              stall_q, stall_d;

    logic              fetch_slot;
    logic              aligned;
    logic [INST_W-1:0] inst_sel;

    // A slot opens when the output register is free or drained this cycle.
    assign fetch_slot = (state_q == RUN) && !fe.redirect_i && !stall_q &&
                        (!valid_q || fe.if_ready_i);
    assign aligned    = (pc_q[1:0] == 2'b00);
    assign inst_sel   = pc_q[2] ? fe.RamReadData[DATA_W-1 -: INST_W]
                                : fe.RamReadData[INST_W-1:0];

    assign fe.RamReadEnable = fetch_slot && aligned;
    assign fe.RamReadAddr   = {pc_q[ADDR_W-1:3], 3'b000};
    assign fe.if_valid_o    = valid_q;
    assign fe.if_pc_o       = opc_q;
    assign fe.if_inst_o     = inst_q;
    assign fe.if_misalign_o = mis_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        opc_d   = opc_q;
        inst_d  = inst_q;
        mis_d   = mis_q;
        stall_d = stall_q;

        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (valid_q && !fe.if_ready_i) state_d = HOLD;
            HOLD:    if (fe.if_ready_i) state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (fe.redirect_i) begin
            state_d = RUN;
            pc_d    = fe.redirect_pc_i;
            valid_d = 1'b0;
            stall_d = 1'b0;
        end else if (fetch_slot) begin
            valid_d = 1'b1;
            opc_d   = pc_q;
            if (aligned) begin
                inst_d = inst_sel;
                mis_d  = 1'b0;
                pc_d   = pc_q + ADDR_W'(4);
            end else begin
                // Misaligned PC: emit a marker entry and park until redirected.
                inst_d  = '0;
                mis_d   = 1'b1;
                stall_d = 1'b1;
            end
        end else if (valid_q && fe.if_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= PC_RESET;
            valid_q <= 1'b0;
            opc_q   <= '0;
            inst_q  <= '0;
            mis_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            inst_q  <= inst_d;
            mis_q   <= mis_d;
            stall_q <= stall_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [63:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + ((fetch_slot && aligned) ? 64'd1 : 64'd0);
        flush_cnt_d = flush_cnt_q + (fe.redirect_i ? 64'd1 : 64'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run against a stream-level reference.
module tb_inst_fetch;
    localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;
    localparam logic [31:0] K      = 32'h1357_9BDF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(64), .DATA_W(64), .INST_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] pf, pl;
`endif

    inst_fetch #(.ADDR_W(64), .DATA_W(64), .INST_W(32), .PC_RESET(PC_RST)) dut (
        .clk (clk),
        .rst (rst),
        .fe  (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (pf),
        .perf_flush_cnt (pl)
`endif
    );

    int errors = 0;
    int checks = 0;

    // RAM contents: each 32-bit word at byte address a holds a ^ K, except the test-plan word.
    function automatic logic [63:0] ram_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0113_0000_0093;
        return {(a[31:0] + 32'd4) ^ K, a[31:0] ^ K};
    endfunction

    function automatic logic [31:0] ref_inst(input logic [63:0] pc);
        if (pc == 64'h8000_0000) return 32'h0000_0093;
        if (pc == 64'h8000_0004) return 32'h0000_0113;
        return pc[31:0] ^ K;
    endfunction

    assign bus.RamReadData = ram_word(bus.RamReadAddr);

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        bus.if_ready_i = rdy;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0;
        cyc(); cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.if_ready_i = 1'b1; bus.redirect_i = 1'b0; bus.redirect_pc_i = '0;
        cyc(); cyc(); #1;
        checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.if_valid_o); end
        checks++; if (bus.if_pc_o !== 64'd0) begin errors++; $display("FAIL rst_pc got %h want 0", bus.if_pc_o); end
        checks++; if (bus.if_inst_o !== 32'd0) begin errors++; $display("FAIL rst_inst got %h want 0", bus.if_inst_o); end
        checks++; if (bus.if_misalign_o !== 1'b0) begin errors++; $display("FAIL rst_mis got %b want 0", bus.if_misalign_o); end
        checks++; if (bus.RamReadEnable !== 1'b0) begin errors++; $display("FAIL rst_ren got %b want 0", bus.RamReadEnable); end
        rst = 1'b0;
        cyc(); #1;
        checks++; if (bus.if_valid_o !== 1'b0 || bus.RamReadEnable !== 1'b1 || bus.RamReadAddr !== PC_RST) begin
            errors++; $display("FAIL first_issue got v=%b en=%b addr=%h want v=0 en=1 addr=%h",
                               bus.if_valid_o, bus.RamReadEnable, bus.RamReadAddr, PC_RST); end
        cyc(); #1;
        checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== PC_RST || bus.if_inst_o !== 32'h93 || bus.if_misalign_o !== 1'b0) begin
            errors++; $display("FAIL first_valid got v=%b pc=%h inst=%h want v=1 pc=80000000 inst=00000093",
                               bus.if_valid_o, bus.if_pc_o, bus.if_inst_o); end
        cyc(); #1;
        checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 64'h8000_0004 || bus.if_inst_o !== 32'h113) begin
            errors++; $display("FAIL second_valid got v=%b pc=%h inst=%h want v=1 pc=80000004 inst=00000113",
                               bus.if_valid_o, bus.if_pc_o, bus.if_inst_o); end
    endtask

    task automatic test_stall();
        bit found;
        do_reset(1'b0);
        cyc(); cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.RamReadEnable !== 1'b0 || bus.if_valid_o !== 1'b1 ||
                          bus.if_pc_o !== PC_RST || bus.if_inst_o !== 32'h93) begin
                errors++; $display("FAIL stall_hold[%0d] got en=%b v=%b pc=%h inst=%h want en=0 v=1 pc=80000000 inst=00000093",
                                   i, bus.RamReadEnable, bus.if_valid_o, bus.if_pc_o, bus.if_inst_o); end
            cyc();
        end
        bus.if_ready_i = 1'b1;
        cyc();
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            #1;
            if (bus.if_valid_o) begin
                found = 1'b1;
                checks++; if (bus.if_pc_o !== 64'h8000_0004 || bus.if_inst_o !== 32'h113) begin
                    errors++; $display("FAIL stall_resume got pc=%h inst=%h want pc=80000004 inst=00000113",
                                       bus.if_pc_o, bus.if_inst_o); end
            end else cyc();
        end
        if (!found) begin checks++; errors++; $display("FAIL stall_resume_timeout got no valid want valid"); end
    endtask

    task automatic test_redirect_hold();
        logic [63:0] w;
        do_reset(1'b0);
        cyc(); cyc(); cyc(); cyc();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h8000_0104;
        #1;
        checks++; if (bus.RamReadEnable !== 1'b0) begin errors++; $display("FAIL redir_noissue got en=%b want 0", bus.RamReadEnable); end
        cyc();
        bus.redirect_i = 1'b0;
        #1;
        checks++; if (bus.if_valid_o !== 1'b0 || bus.RamReadEnable !== 1'b1 || bus.RamReadAddr !== 64'h8000_0100) begin
            errors++; $display("FAIL redir_flush got v=%b en=%b addr=%h want v=0 en=1 addr=80000100",
                               bus.if_valid_o, bus.RamReadEnable, bus.RamReadAddr); end
        cyc(); #1;
        w = ram_word(64'h8000_0100);
        checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 64'h8000_0104 || bus.if_inst_o !== w[63:32]) begin
            errors++; $display("FAIL redir_target got v=%b pc=%h inst=%h want v=1 pc=80000104 inst=%h",
                               bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, w[63:32]); end
    endtask

    task automatic test_misalign();
        bus.if_ready_i = 1'b1;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h8000_0002;
        cyc();
        bus.redirect_i = 1'b0;
        #1;
        checks++; if (bus.if_valid_o !== 1'b0 || bus.RamReadEnable !== 1'b0) begin
            errors++; $display("FAIL mis_noread got v=%b en=%b want v=0 en=0", bus.if_valid_o, bus.RamReadEnable); end
        cyc(); #1;
        checks++; if (bus.if_valid_o !== 1'b1 || bus.if_misalign_o !== 1'b1 || bus.if_inst_o !== 32'd0 || bus.if_pc_o !== 64'h8000_0002) begin
            errors++; $display("FAIL mis_entry got v=%b mis=%b inst=%h pc=%h want v=1 mis=1 inst=0 pc=80000002",
                               bus.if_valid_o, bus.if_misalign_o, bus.if_inst_o, bus.if_pc_o); end
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            checks++; if (bus.if_valid_o !== 1'b0 || bus.RamReadEnable !== 1'b0) begin
                errors++; $display("FAIL mis_parked[%0d] got v=%b en=%b want 0 0", i, bus.if_valid_o, bus.RamReadEnable); end
        end
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h8000_0010;
        cyc();
        bus.redirect_i = 1'b0;
        cyc(); #1;
        checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 64'h8000_0010 || bus.if_misalign_o !== 1'b0 ||
                      bus.if_inst_o !== ref_inst(64'h8000_0010)) begin
            errors++; $display("FAIL mis_recover got v=%b pc=%h mis=%b inst=%h want v=1 pc=80000010 mis=0 inst=%h",
                               bus.if_valid_o, bus.if_pc_o, bus.if_misalign_o, bus.if_inst_o, ref_inst(64'h8000_0010)); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) cyc();
        rst = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h8000_0200;
        cyc(); #1;
        checks++; if (bus.if_valid_o !== 1'b0 || bus.if_pc_o !== 64'd0 || bus.if_inst_o !== 32'd0 ||
                      bus.if_misalign_o !== 1'b0 || bus.RamReadEnable !== 1'b0) begin
            errors++; $display("FAIL midrst_clear got v=%b pc=%h inst=%h mis=%b en=%b want all 0",
                               bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, bus.if_misalign_o, bus.RamReadEnable); end
        rst = 1'b0; bus.redirect_i = 1'b0;
        cyc(); cyc(); #1;
        checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== PC_RST || bus.if_inst_o !== 32'h93) begin
            errors++; $display("FAIL midrst_resume got v=%b pc=%h inst=%h want v=1 pc=80000000 inst=00000093",
                               bus.if_valid_o, bus.if_pc_o, bus.if_inst_o); end
    endtask

    task automatic test_random();
        logic [63:0] exp_pc, p_pc;
        logic [31:0] p_inst, want_inst;
        logic        dead, p_hold, p_mis, want_mis;
        int          accepted;
        do_reset(1'b1);
        exp_pc = PC_RST; dead = 1'b0; p_hold = 1'b0; accepted = 0;
        p_pc = '0; p_inst = '0; p_mis = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bus.if_ready_i    = ($urandom % 4) != 0;
            bus.redirect_i    = ($urandom % 20) == 0;
            bus.redirect_pc_i = PC_RST + 64'($urandom_range(0, 1023) << 2) + (($urandom % 8) == 0 ? 64'd2 : 64'd0);
            #1;
            if (bus.if_valid_o && p_hold) begin
                checks++; if (bus.if_pc_o !== p_pc || bus.if_inst_o !== p_inst || bus.if_misalign_o !== p_mis) begin
                    errors++; $display("FAIL rnd_stable c=%0d got pc=%h inst=%h mis=%b want pc=%h inst=%h mis=%b",
                                       c, bus.if_pc_o, bus.if_inst_o, bus.if_misalign_o, p_pc, p_inst, p_mis); end
            end
            if ((bus.if_valid_o && !bus.if_ready_i) || bus.redirect_i) begin
                checks++; if (bus.RamReadEnable !== 1'b0 || bus.RamReadAddr[2:0] !== 3'b000) begin
                    errors++; $display("FAIL rnd_noissue c=%0d got en=%b want 0", c, bus.RamReadEnable); end
            end
            if (dead) begin
                checks++; if (bus.if_valid_o !== 1'b0) begin
                    errors++; $display("FAIL rnd_parked c=%0d got v=1 pc=%h want v=0", c, bus.if_pc_o); end
            end else if (bus.if_valid_o && bus.if_ready_i) begin
                want_mis  = (exp_pc[1:0] != 2'b00);
                want_inst = want_mis ? 32'd0 : ref_inst(exp_pc);
                checks++; if (bus.if_pc_o !== exp_pc || bus.if_inst_o !== want_inst || bus.if_misalign_o !== want_mis) begin
                    errors++; $display("FAIL rnd_accept c=%0d got pc=%h inst=%h mis=%b want pc=%h inst=%h mis=%b",
                                       c, bus.if_pc_o, bus.if_inst_o, bus.if_misalign_o, exp_pc, want_inst, want_mis); end
                accepted++;
                if (want_mis) dead = 1'b1;
                else exp_pc = exp_pc + 64'd4;
            end
            if (bus.redirect_i) begin
                exp_pc = bus.redirect_pc_i;
                dead   = 1'b0;
            end
            p_hold = bus.if_valid_o && !bus.if_ready_i && !bus.redirect_i;
            p_pc = bus.if_pc_o; p_inst = bus.if_inst_o; p_mis = bus.if_misalign_o;
            cyc();
        end
        checks++; if (accepted < 500) begin
            errors++; $display("FAIL rnd_progress got %0d accepted want >= 500", accepted); end
        bus.redirect_i = 1'b0;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        int acc;
        do_reset(1'b1);
        acc = 0;
        for (int c = 0; c < 200 && acc < 10; c++) begin
            bus.redirect_i = 1'b0;
            if (bus.if_valid_o) begin
                acc++;
                if (acc == 5 || acc == 10) begin
                    bus.redirect_i = 1'b1;
                    bus.redirect_pc_i = 64'h8000_0040;
                end
            end
            cyc();
        end
        bus.redirect_i = 1'b0;
        #1;
        checks++; if (acc != 10 || pf !== 64'd10 || pl !== 64'd2) begin
            errors++; $display("FAIL perf_counts got acc=%0d fetch=%0d flush=%0d want 10 10 2", acc, pf, pl); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.if_ready_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0;
        @(negedge clk);
        test_reset();
        test_stall();
        test_redirect_hold();
        test_misalign();
        test_reset_mid();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
